// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: data + control payload behind a valid/ready handshake,
// with stall/flush control, an optional skid slot and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic              skid_full_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              main_free_s;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              valid_s;
  logic [DATA_W-1:0] data_s;
  logic [CTRL_W-1:0] ctrl_s;
  logic              skid_full_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [CNT_W-1:0]  cnt_s;

  // Handshake: the main slot can take a new entry when empty or draining this cycle.
  always_comb begin
    main_free_s = !valid_r || out_ready;
    if (SKID != 32'sd0) begin
      in_ready_s = !skid_full_r && !stall && !flush;
    end else begin
      in_ready_s = !stall && !flush && main_free_s;
    end
    in_fire_s  = in_valid && in_ready_s;
    out_fire_s = valid_r && out_ready;
  end

  // Next slot contents; the skid entry always moves ahead of new input to keep FIFO order.
  always_comb begin
    valid_s     = valid_r;
    data_s      = data_r;
    ctrl_s      = ctrl_r;
    skid_full_s = skid_full_r;
    skid_data_s = skid_data_r;
    skid_ctrl_s = skid_ctrl_r;
    if (flush) begin
      valid_s     = 1'b0;
      ctrl_s      = '0;
      skid_full_s = 1'b0;
      skid_data_s = '0;
      skid_ctrl_s = '0;
    end else if (main_free_s) begin
      if (skid_full_r) begin
        valid_s     = 1'b1;
        data_s      = skid_data_r;
        ctrl_s      = skid_ctrl_r;
        skid_full_s = 1'b0;
        skid_data_s = '0;
        skid_ctrl_s = '0;
      end else if (in_fire_s) begin
        valid_s = 1'b1;
        data_s  = in_data;
        ctrl_s  = in_ctrl;
      end else if (out_fire_s) begin
        // Bubble: control zeroed so downstream enables stay inert; data left as is.
        valid_s = 1'b0;
        ctrl_s  = '0;
      end else begin
        valid_s = valid_r;
      end
    end else if (in_fire_s) begin
      skid_full_s = 1'b1;
      skid_data_s = in_data;
      skid_ctrl_s = in_ctrl;
    end else begin
      skid_full_s = skid_full_r;
    end
  end

  // Bubble counter: empty cycles the downstream was ready to consume, saturating.
  always_comb begin
    if (!valid_r && out_ready && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers; reset clears everything so no partial transfer survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r     <= 1'b0;
      data_r      <= '0;
      ctrl_r      <= '0;
      skid_full_r <= 1'b0;
      skid_data_r <= '0;
      skid_ctrl_r <= '0;
      cnt_r       <= '0;
    end else begin
      valid_r     <= valid_s;
      data_r      <= data_s;
      ctrl_r      <= ctrl_s;
      skid_full_r <= skid_full_s;
      skid_data_r <= skid_data_s;
      skid_ctrl_r <= skid_ctrl_s;
      cnt_r       <= cnt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = valid_r;
  assign out_data   = data_r;
  assign out_ctrl   = ctrl_r;
  assign bubble_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (SKID=0, SKID=1, SKID=0 with a
// 4-bit counter) share one stimulus stream; each has its own FIFO reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [95:0] in_data;
  logic [11:0] in_ctrl;
  logic        stall;
  logic        flush;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [95:0] d, input logic [11:0] c,
                     input logic st, input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int SK = (g == 1) ? 1 : 0;
    localparam int CW = (g == 2) ? 4 : 32;

    logic          in_ready;
    logic          out_valid;
    logic [95:0]   out_data;
    logic [11:0]   out_ctrl;
    logic [CW-1:0] bubble_cnt;

    logic [107:0]  q [$];
    logic [CW-1:0] cnt;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(12), .SKID(SK), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
    );

    // Reference: the stage is a FIFO of capacity 1 (or 2 with skid); a one-deep stage
    // can also accept when its single entry leaves in the same cycle.
    function automatic logic mready();
      if (stall || flush) return 1'b0;
      if (SK == 1) return q.size() < 2;
      return (q.size() == 0) || out_ready;
    endfunction

    // Stimulus side: record what this cycle's inputs should enqueue.
    initial begin : drv
      logic acc, fl;
      logic [107:0] item;
      forever begin
        @(posedge clk);
        #2;
        acc  = in_valid && mready();
        fl   = flush;
        item = {in_ctrl, in_data};
        @(negedge clk);
        #1;
        if (rst || fl) q.delete();
        else if (acc) q.push_back(item);
      end
    end

    // Monitor: compare presented outputs against the head of the expected queue.
    initial begin : mon
      logic [107:0] head;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          cnt = '0;
        end
        chk($sformatf("u%0d_in_ready", g), 128'(in_ready), 128'(mready()));
        chk($sformatf("u%0d_out_valid", g), 128'(out_valid), 128'(q.size() > 0));
        if (q.size() > 0) begin
          head = q[0];
          chk($sformatf("u%0d_out_data", g), 128'(out_data), 128'(head[95:0]));
          chk($sformatf("u%0d_out_ctrl", g), 128'(out_ctrl), 128'(head[107:96]));
        end else begin
          chk($sformatf("u%0d_bubble_ctrl", g), 128'(out_ctrl), 128'(12'h000));
        end
        chk($sformatf("u%0d_bubble_cnt", g), 128'(bubble_cnt), 128'(cnt));
        if (!rst) begin
          if (q.size() > 0) begin
            if (out_ready) void'(q.pop_front());
          end else if (out_ready && (cnt != {CW{1'b1}})) begin
            cnt = cnt + CW'(1);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // streaming
    cyc(1'b1, 96'h1, 12'h0A1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 96'h2, 12'h0A2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 96'h3, 12'h0A3, 1'b0, 1'b0, 1'b1);
    // stall two cycles, then capture 0xAA
    cyc(1'b1, 96'hAA, 12'h3C3, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 96'hAA, 12'h3C3, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 96'hAA, 12'h3C3, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b1);
    // flush with a held entry and a pending 0x55
    cyc(1'b1, 96'h77, 12'hF0F, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 96'h55, 12'hFFF, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b1);
    // backpressure
    cyc(1'b1, 96'h10, 12'h011, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 96'h20, 12'h022, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 96'h30, 12'h033, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b1);
    // asynchronous reset while holding a valid entry
    cyc(1'b1, 96'h99, 12'h199, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1 chk("pre_rst_valid", 128'(g_u[0].out_valid), 128'(1'b1));
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 1; k++) begin
      chk("async_rst_valid0", 128'(g_u[0].out_valid), 128'(1'b0));
      chk("async_rst_ctrl0", 128'(g_u[0].out_ctrl), 128'(12'h000));
      chk("async_rst_cnt0", 128'(g_u[0].bubble_cnt), 128'(32'd0));
      chk("async_rst_valid1", 128'(g_u[1].out_valid), 128'(1'b0));
      chk("async_rst_cnt2", 128'(g_u[2].bubble_cnt), 128'(4'd0));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, 12'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    // counter saturation from a clean reset
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 96'h0, 12'h000, 1'b0, 1'b0, 1'b1);
    #1;
    chk("sat_cnt4", 128'(g_u[2].bubble_cnt), 128'(4'hF));
    chk("cnt32_20", 128'(g_u[0].bubble_cnt), 128'(32'd20));

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
